inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit_pkg.sv | 14 +
 rtl/inst_fetch_unit_rom.sv | 23 ++
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch definitions: state encodings and the NOP/HALT instruction words.
// The cpu decoder imports the same NOP_WORD and HALT_WORD_DEF.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

endpackage

// File: rtl/inst_fetch_unit_rom.sv
// Local instruction memory: DEPTH x 32, synchronous write from the loader,
// combinational read addressed by the current fetch word index.
module inst_fetch_unit_rom #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds a loaded program and streams it to the cpu Inst
// input with one-cycle latency, supporting stall, redirect and HALT.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [31:0]       pc,
  output logic              halted
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc_idx, w_pc_idx_nxt;
  logic [31:0]       r_inst, w_inst_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_halted, w_halted_nxt;
  logic              w_we;
  logic [31:0]       w_rd_data;
  logic              w_unused_target;

  inst_fetch_unit_rom #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(r_pc_idx),
    .o_rdata(w_rd_data)
  );

  // Target bits outside the word index are dropped: PC is modulo DEPTH*4, word aligned.
  assign w_unused_target = ^{redirect_target[31:ADDR_W+2], redirect_target[1:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_idx_nxt = r_pc_idx;
    w_inst_nxt   = r_inst;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    w_we         = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (load_en) begin
          w_we = 1'b1;
        end else if (start) begin
          w_state_nxt  = S_RUN;
          w_pc_idx_nxt = '0;
          w_inst_nxt   = NOP_WORD;
          w_valid_nxt  = 1'b0;
          w_halted_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (redirect) begin
          w_pc_idx_nxt = redirect_target[ADDR_W+1:2];
          w_inst_nxt   = NOP_WORD;
          w_valid_nxt  = 1'b0;
        end else if (!stall) begin
          if (w_rd_data == HALT_WORD) begin
            // PC stays on the HALT word; it is never shown as a valid instruction.
            w_state_nxt  = S_HALT;
            w_inst_nxt   = NOP_WORD;
            w_valid_nxt  = 1'b0;
            w_halted_nxt = 1'b1;
          end else begin
            w_inst_nxt   = w_rd_data;
            w_valid_nxt  = 1'b1;
            w_pc_idx_nxt = r_pc_idx + ADDR_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc_idx <= '0;
      r_inst   <= NOP_WORD;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc_idx <= w_pc_idx_nxt;
      r_inst   <= w_inst_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_valid;
  assign pc         = {{(30 - ADDR_W){1'b0}}, r_pc_idx, 2'b00};
  assign halted     = r_halted;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a vector table for fetch/stall/redirect/HALT
// plus hand sequences for loading, async reset, and a DEPTH=4 wrap instance.
module tb_inst_fetch_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] I0   = 32'h2001_0001;
  localparam logic [31:0] I1   = 32'h2002_0001;
  localparam logic [31:0] I2   = 32'h0021_0820;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, start, stall, redirect;
  logic [5:0]  load_addr;
  logic [31:0] load_data, redirect_target;
  logic [31:0] inst, pc;
  logic        inst_valid, halted;

  logic        b_load_en, b_start;
  logic [1:0]  b_load_addr;
  logic [31:0] b_load_data;
  logic [31:0] b_inst, b_pc;
  logic        b_inst_valid, b_halted;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  inst_fetch_unit u_dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .pc             (pc),
    .halted         (halted)
  );

  inst_fetch_unit #(
    .DEPTH (4),
    .ADDR_W(2)
  ) u_dut4 (
    .clk            (clk),
    .reset          (reset),
    .load_en        (b_load_en),
    .load_addr      (b_load_addr),
    .load_data      (b_load_data),
    .start          (b_start),
    .stall          (1'b0),
    .redirect       (1'b0),
    .redirect_target(32'h0),
    .inst           (b_inst),
    .inst_valid     (b_inst_valid),
    .pc             (b_pc),
    .halted         (b_halted)
  );

  typedef struct {
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [31:0] ei, input logic ev,
                       input logic [31:0] ep, input logic eh);
    chk({name, " inst"}, inst, ei);
    chk({name, " valid"}, {31'b0, inst_valid}, {31'b0, ev});
    chk({name, " pc"}, pc, ep);
    chk({name, " halted"}, {31'b0, halted}, {31'b0, eh});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [5:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic add(input logic st, input logic sl, input logic rd, input logic [31:0] tg,
                     input logic [31:0] ei, input logic ev, input logic [31:0] ep,
                     input logic eh);
    vec_t v;
    v.start = st; v.stall = sl; v.redirect = rd; v.target = tg;
    v.exp_inst = ei; v.exp_valid = ev; v.exp_pc = ep; v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  initial begin
    // Plain run to HALT
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, I0, 1, 4, 0);
    add(0, 0, 0, 0, I1, 1, 8, 0);
    add(0, 0, 0, 0, I2, 1, 12, 0);
    add(0, 0, 0, 0, 0, 0, 12, 1);
    add(0, 1, 1, 8, 0, 0, 12, 1);  // stall/redirect ignored in HALT
    // Two stall cycles after the first fetch
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, I0, 1, 4, 0);
    add(0, 1, 0, 0, I0, 1, 4, 0);
    add(0, 1, 0, 0, I0, 1, 4, 0);
    add(0, 0, 0, 0, I1, 1, 8, 0);
    add(0, 0, 0, 0, I2, 1, 12, 0);
    add(0, 0, 0, 0, 0, 0, 12, 1);
    // Redirect at pc=8 to misaligned 1, then redirect+stall to 8
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, I0, 1, 4, 0);
    add(0, 0, 0, 0, I1, 1, 8, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, I0, 1, 4, 0);
    add(0, 1, 1, 8, 0, 0, 8, 0);
    add(0, 0, 0, 0, I2, 1, 12, 0);
    add(0, 0, 0, 0, 0, 0, 12, 1);

    reset = 1'b1;
    load_en = 0; start = 0; stall = 0; redirect = 0;
    load_addr = '0; load_data = '0; redirect_target = '0;
    b_load_en = 0; b_start = 0; b_load_addr = '0; b_load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    chk_a("idle", 32'h0, 1'b0, 32'h0, 1'b0);

    load_a(0, I0);
    load_a(1, I1);
    load_a(2, I2);
    load_a(3, HALT);

    for (int i = 0; i < vecs.size(); i++) begin
      start           = vecs[i].start;
      stall           = vecs[i].stall;
      redirect        = vecs[i].redirect;
      redirect_target = vecs[i].target;
      step();
      start = 0; stall = 0; redirect = 0;
      chk_a($sformatf("vec%0d", i), vecs[i].exp_inst, vecs[i].exp_valid,
            vecs[i].exp_pc, vecs[i].exp_halted);
    end

    // load_en during RUN must not touch memory
    start = 1; step(); start = 0;
    chk_a("rerun", 32'h0, 1'b0, 32'h0, 1'b0);
    load_en = 1; load_addr = 6'd1; load_data = 32'hDEAD_BEEF;
    step();
    load_en = 0;
    chk_a("runload0", I0, 1'b1, 32'd4, 1'b0);
    step();
    chk_a("runload1", I1, 1'b1, 32'd8, 1'b0);
    step();
    step();
    chk_a("runload_halt", 32'h0, 1'b0, 32'd12, 1'b1);

    // start with load_en in HALT: write wins, start ignored
    load_en = 1; load_addr = 6'd4; load_data = HALT; start = 1;
    step();
    load_en = 0; start = 0;
    chk_a("ld_start", 32'h0, 1'b0, 32'd12, 1'b1);
    load_a(3, I2);
    start = 1; step(); start = 0;
    chk_a("hrun", 32'h0, 1'b0, 32'h0, 1'b0);
    step(); chk_a("hrun0", I0, 1'b1, 32'd4, 1'b0);
    step(); chk_a("hrun1", I1, 1'b1, 32'd8, 1'b0);
    step(); chk_a("hrun2", I2, 1'b1, 32'd12, 1'b0);
    step(); chk_a("hrun3", I2, 1'b1, 32'd16, 1'b0);
    step(); chk_a("hrun4", 32'h0, 1'b0, 32'd16, 1'b1);

    // Asynchronous reset between edges
    start = 1; step(); start = 0;
    step();
    step();
    chk_a("pre_rst", I1, 1'b1, 32'd8, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_a("async_rst", 32'h0, 1'b0, 32'h0, 1'b0);
    #1 reset = 1'b0;
    start = 1; step(); start = 0;
    chk_a("post_rst", 32'h0, 1'b0, 32'h0, 1'b0);
    step(); chk_a("post_rst0", I0, 1'b1, 32'd4, 1'b0);

    // DEPTH=4 wrap with no HALT loaded
    for (int i = 0; i < 4; i++) begin
      b_load_en   = 1'b1;
      b_load_addr = 2'(i);
      b_load_data = 32'h11 * (i + 1);
      step();
    end
    b_load_en = 1'b0;
    b_start = 1; step(); b_start = 0;
    chk("wrap start pc", b_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wrap%0d inst", i), b_inst, 32'h11 * ((i % 4) + 1));
      chk($sformatf("wrap%0d pc", i), b_pc, 32'(((i + 1) % 4) * 4));
      chk($sformatf("wrap%0d valid", i), {31'b0, b_inst_valid}, 32'h1);
    end
    chk("wrap halted", {31'b0, b_halted}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
